pll_lock_rst_seq: RTL and testbench

//  Downstream consumer of the FCCC PLL wrapper outputs. Runs on one PLL global clock and

---
 rtl/pll_lock_rst_seq.sv | 171 +++++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_seq.sv
// Lock-qualified reset sequencer: holds NUM_RST active-low resets until the PLL lock is
// stable, releases them in staggered order, and drops them all together on a lock loss.
module pll_lock_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int NUM_RST     = 4,
  parameter int LOSS_FILT   = 3,
  parameter int CNT_W       = 8
) (
  input  logic               CLK0,
  input  logic               RESETN,
  input  logic               LOCK,
  input  logic               SW_RST_REQ,
  output logic [NUM_RST-1:0] RST_N_OUT,
  output logic               READY,
  output logic               LOCK_LOST,
  output logic [CNT_W-1:0]   LOSS_CNT,
  output logic [1:0]         STATE
);

  localparam int STB_W = $clog2(STABLE_CYC + 1);
  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP + 1) : 1;
  localparam int FLT_W = (LOSS_FILT > 1) ? $clog2(LOSS_FILT + 1) : 1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic                   w_loss;
  logic                   w_armed;

  state_t             r_state,     w_state_next;
  logic [STB_W-1:0]   r_stb_cnt,   w_stb_cnt_next;
  logic [GAP_W-1:0]   r_gap_cnt,   w_gap_cnt_next;
  logic [FLT_W-1:0]   r_flt_cnt,   w_flt_cnt_next;
  logic [NUM_RST-1:0] r_rst_n,     w_rst_n_next;
  logic               r_ready,     w_ready_next;
  logic               r_lock_lost, w_lock_lost_next;
  logic [CNT_W-1:0]   r_loss_cnt,  w_loss_cnt_next;

  // LOCK is asynchronous to CLK0; only the last synchroniser stage is ever consumed.
  always_ff @(posedge CLK0) begin
    if (!RESETN) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], LOCK};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  assign w_armed  = (r_state == S_RELEASE) || (r_state == S_RUN);
  // The loss fires in the cycle that observes the LOSS_FILT-th consecutive low sample.
  assign w_loss   = w_armed && !w_lock_s && (r_flt_cnt == FLT_W'(LOSS_FILT - 1));

  always_ff @(posedge CLK0) begin
    if (!RESETN) begin
      r_state     <= S_WAIT_LOCK;
      r_stb_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_flt_cnt   <= '0;
      r_rst_n     <= '0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_loss_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_stb_cnt   <= w_stb_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_flt_cnt   <= w_flt_cnt_next;
      r_rst_n     <= w_rst_n_next;
      r_ready     <= w_ready_next;
      r_lock_lost <= w_lock_lost_next;
      r_loss_cnt  <= w_loss_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_stb_cnt_next   = r_stb_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_flt_cnt_next   = '0;
    w_rst_n_next     = r_rst_n;
    w_ready_next     = r_ready;
    w_lock_lost_next = 1'b0;
    w_loss_cnt_next  = r_loss_cnt;

    if (w_armed && !w_lock_s) begin
      w_flt_cnt_next = r_flt_cnt + FLT_W'(1);
    end

    // A lock loss outranks a simultaneous software request so the event is still counted.
    if (w_loss) begin
      w_state_next     = S_WAIT_LOCK;
      w_stb_cnt_next   = '0;
      w_gap_cnt_next   = '0;
      w_flt_cnt_next   = '0;
      w_rst_n_next     = '0;
      w_ready_next     = 1'b0;
      w_lock_lost_next = 1'b1;
      if (r_loss_cnt != {CNT_W{1'b1}}) begin
        w_loss_cnt_next = r_loss_cnt + CNT_W'(1);
      end
    end else if (SW_RST_REQ && (r_state != S_WAIT_LOCK)) begin
      w_state_next   = S_WAIT_LOCK;
      w_stb_cnt_next = '0;
      w_gap_cnt_next = '0;
      w_flt_cnt_next = '0;
      w_rst_n_next   = '0;
      w_ready_next   = 1'b0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          w_rst_n_next   = '0;
          w_ready_next   = 1'b0;
          w_gap_cnt_next = '0;
          if (w_lock_s) begin
            w_state_next   = S_STABLE;
            w_stb_cnt_next = STB_W'(1);
          end
        end
        S_STABLE: begin
          if (!w_lock_s) begin
            w_state_next   = S_WAIT_LOCK;
            w_stb_cnt_next = '0;
          end else if (r_stb_cnt == STB_W'(STABLE_CYC - 1)) begin
            w_state_next   = S_RELEASE;
            w_stb_cnt_next = '0;
            w_gap_cnt_next = '0;
            w_rst_n_next   = NUM_RST'(1);
          end else begin
            w_stb_cnt_next = r_stb_cnt + STB_W'(1);
          end
        end
        S_RELEASE: begin
          if (&r_rst_n) begin
            w_state_next = S_RUN;
            w_ready_next = 1'b1;
          end else if (r_gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
            // Shifting a 1 in from the bottom keeps the release order monotone.
            w_rst_n_next   = (r_rst_n << 1) | NUM_RST'(1);
            w_gap_cnt_next = '0;
          end else begin
            w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
          end
        end
        S_RUN: begin
          w_rst_n_next = '1;
          w_ready_next = 1'b1;
        end
        default: begin
          w_state_next = S_WAIT_LOCK;
          w_rst_n_next = '0;
          w_ready_next = 1'b0;
        end
      endcase
    end
  end

  assign RST_N_OUT = r_rst_n;
  assign READY     = r_ready;
  assign LOCK_LOST = r_lock_lost;
  assign LOSS_CNT  = r_loss_cnt;
  assign STATE     = r_state;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: expected reset-bit changes and lock-loss pulses are queued
// with their cycle numbers as stimulus is driven and matched by a negedge monitor.
module tb_pll_lock_rst_seq;

  localparam int STABLE_CYC = 8;
  localparam int STAGE_GAP  = 4;
  localparam int CNT_MAX    = 3;

  logic       CLK0;
  logic       RESETN;
  logic       LOCK;
  logic       SW_RST_REQ;
  logic [3:0] RST_N_OUT;
  logic       READY;
  logic       LOCK_LOST;
  logic [1:0] LOSS_CNT;
  logic [1:0] STATE;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } rst_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] cnt;
  } loss_exp_t;

  rst_exp_t  rst_q[$];
  loss_exp_t loss_q[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         exp_cnt = 0;
  logic [3:0] exp_rst_last = '0;
  logic [3:0] prev_rst = '0;
  logic       mon_en = 1'b0;

  pll_lock_rst_seq #(
    .SYNC_STAGES(2),
    .STABLE_CYC (STABLE_CYC),
    .STAGE_GAP  (STAGE_GAP),
    .NUM_RST    (4),
    .LOSS_FILT  (3),
    .CNT_W      (2)
  ) dut (
    .CLK0      (CLK0),
    .RESETN    (RESETN),
    .LOCK      (LOCK),
    .SW_RST_REQ(SW_RST_REQ),
    .RST_N_OUT (RST_N_OUT),
    .READY     (READY),
    .LOCK_LOST (LOCK_LOST),
    .LOSS_CNT  (LOSS_CNT),
    .STATE     (STATE)
  );

  initial CLK0 = 1'b0;
  always #5 CLK0 = ~CLK0;

  initial begin
    forever begin
      @(posedge CLK0);
      cyc++;
    end
  end

  // Scoreboard monitor: every change of RST_N_OUT and every LOCK_LOST pulse must match a queued entry.
  initial begin
    rst_exp_t  re;
    loss_exp_t le;
    forever begin
      @(negedge CLK0);
      if (mon_en && (RST_N_OUT !== prev_rst)) begin
        checks++;
        if (rst_q.size() == 0) begin
          errors++;
          $display("FAIL rst_change cyc=%0d got=%b expected no change", cyc, RST_N_OUT);
        end else begin
          re = rst_q.pop_front();
          if ((re.cyc != cyc) || (re.val !== RST_N_OUT)) begin
            errors++;
            $display("FAIL rst_change got=%b at cyc %0d expected=%b at cyc %0d",
                     RST_N_OUT, cyc, re.val, re.cyc);
          end else begin
            $display("rst_change cyc=%0d RST_N_OUT=%b ok", cyc, RST_N_OUT);
          end
        end
      end
      prev_rst = RST_N_OUT;
      if (mon_en && (LOCK_LOST !== 1'b0)) begin
        checks++;
        if (loss_q.size() == 0) begin
          errors++;
          $display("FAIL lock_lost cyc=%0d got pulse=%b expected no pulse", cyc, LOCK_LOST);
        end else begin
          le = loss_q.pop_front();
          if ((le.cyc != cyc) || (le.cnt !== LOSS_CNT)) begin
            errors++;
            $display("FAIL lock_lost got cyc=%0d cnt=%0d expected cyc=%0d cnt=%0d",
                     cyc, LOSS_CNT, le.cyc, le.cnt);
          end else begin
            $display("lock_lost cyc=%0d LOSS_CNT=%0d ok", cyc, LOSS_CNT);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected bench to finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK0);
  endtask

  // Queue the first nbits staged releases counted from t0 (first cycle with lock_s=1).
  task automatic push_release(input int t0, input int nbits);
    rst_exp_t e;
    for (int k = 0; k < nbits; k++) begin
      e.cyc = t0 + STABLE_CYC + k * STAGE_GAP;
      e.val = 4'((1 << (k + 1)) - 1);
      rst_q.push_back(e);
      exp_rst_last = e.val;
    end
  endtask

  task automatic push_drop(input int c);
    rst_exp_t e;
    e.cyc = c;
    e.val = 4'b0000;
    rst_q.push_back(e);
    exp_rst_last = 4'b0000;
  endtask

  task automatic push_loss(input int c);
    loss_exp_t e;
    exp_cnt = (exp_cnt >= CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    e.cyc = c;
    e.cnt = 2'(exp_cnt);
    loss_q.push_back(e);
  endtask

  // Leaves the DUT held in reset at a negedge; the caller releases RESETN.
  task automatic do_reset(input logic lock_lvl);
    @(negedge CLK0);
    RESETN     = 1'b0;
    LOCK       = lock_lvl;
    SW_RST_REQ = 1'b0;
    if (exp_rst_last != 4'b0000) push_drop(cyc + 1);
    exp_cnt = 0;
    repeat (3) @(negedge CLK0);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks += 5;
    if (RST_N_OUT !== 4'b0000) begin errors++; $display("FAIL reset_rst got=%b expected=0000", RST_N_OUT); end
    if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b expected=0", READY); end
    if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got=%b expected=0", LOCK_LOST); end
    if (LOSS_CNT !== 2'd0) begin errors++; $display("FAIL reset_loss_cnt got=%0d expected=0", LOSS_CNT); end
    if (STATE !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d expected=0", STATE); end
    $display("test_reset done cyc=%0d", cyc);
    prev_rst = RST_N_OUT;
    mon_en   = 1'b1;
  endtask

  task automatic test_release_seq();
    int t0;
    RESETN = 1'b1;
    t0 = cyc + 2;
    push_release(t0, 4);
    wait_to(t0 + 7);
    checks++;
    if (STATE !== 2'd1) begin errors++; $display("FAIL seq_stable_state got=%0d expected=1", STATE); end
    wait_to(t0 + 8);
    checks++;
    if (STATE !== 2'd2) begin errors++; $display("FAIL seq_release_state got=%0d expected=2", STATE); end
    wait_to(t0 + 20);
    checks++;
    if (READY !== 1'b0) begin errors++; $display("FAIL seq_ready_early got=%b expected=0", READY); end
    wait_to(t0 + 21);
    checks += 2;
    if (READY !== 1'b1) begin errors++; $display("FAIL seq_ready got=%b expected=1", READY); end
    if (STATE !== 2'd3) begin errors++; $display("FAIL seq_run_state got=%0d expected=3", STATE); end
    $display("test_release_seq done cyc=%0d", cyc);
  endtask

  task automatic test_stable_glitch();
    int t0;
    do_reset(1'b1);
    RESETN = 1'b1;
    t0 = cyc + 2;
    wait_to(t0 + 3);
    LOCK = 1'b0;
    wait_to(t0 + 4);
    LOCK = 1'b1;
    wait_to(t0 + 5);
    checks++;
    if (STATE !== 2'd1) begin errors++; $display("FAIL glitch_pre_state got=%0d expected=1", STATE); end
    wait_to(t0 + 6);
    push_release(t0 + 6, 4);
    checks += 3;
    if (STATE !== 2'd0) begin errors++; $display("FAIL glitch_state got=%0d expected=0", STATE); end
    if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL glitch_lock_lost got=%b expected=0", LOCK_LOST); end
    if (LOSS_CNT !== 2'd0) begin errors++; $display("FAIL glitch_loss_cnt got=%0d expected=0", LOSS_CNT); end
    wait_to(t0 + 6 + 21);
    checks++;
    if (READY !== 1'b1) begin errors++; $display("FAIL glitch_ready got=%b expected=1", READY); end
    $display("test_stable_glitch done cyc=%0d", cyc);
  endtask

  task automatic test_loss_filter();
    int n;
    n = cyc;
    LOCK = 1'b0;
    wait_to(n + 2);
    LOCK = 1'b1;
    wait_to(n + 8);
    checks += 2;
    if (RST_N_OUT !== 4'b1111) begin errors++; $display("FAIL short_drop_rst got=%b expected=1111", RST_N_OUT); end
    if (STATE !== 2'd3) begin errors++; $display("FAIL short_drop_state got=%0d expected=3", STATE); end
    n = cyc;
    LOCK = 1'b0;
    push_drop(n + 5);
    push_loss(n + 5);
    wait_to(n + 4);
    checks++;
    if (RST_N_OUT !== 4'b1111) begin errors++; $display("FAIL loss_early_rst got=%b expected=1111", RST_N_OUT); end
    wait_to(n + 5);
    checks += 3;
    if (STATE !== 2'd0) begin errors++; $display("FAIL loss_state got=%0d expected=0", STATE); end
    if (READY !== 1'b0) begin errors++; $display("FAIL loss_ready got=%b expected=0", READY); end
    if (LOSS_CNT !== 2'(exp_cnt)) begin errors++; $display("FAIL loss_cnt got=%0d expected=%0d", LOSS_CNT, exp_cnt); end
    LOCK = 1'b1;
    push_release(n + 7, 4);
    wait_to(n + 7 + 21);
    checks++;
    if (READY !== 1'b1) begin errors++; $display("FAIL loss_rerun_ready got=%b expected=1", READY); end
    $display("test_loss_filter done cyc=%0d", cyc);
  endtask

  task automatic test_sw_req();
    int n;
    n = cyc;
    SW_RST_REQ = 1'b1;
    push_drop(n + 1);
    push_release(n + 1, 4);
    wait_to(n + 1);
    SW_RST_REQ = 1'b0;
    checks += 3;
    if (STATE !== 2'd0) begin errors++; $display("FAIL sw_state got=%0d expected=0", STATE); end
    if (LOSS_CNT !== 2'(exp_cnt)) begin errors++; $display("FAIL sw_loss_cnt got=%0d expected=%0d", LOSS_CNT, exp_cnt); end
    if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL sw_lock_lost got=%b expected=0", LOCK_LOST); end
    wait_to(n + 1 + 21);
    checks += 2;
    if (READY !== 1'b1) begin errors++; $display("FAIL sw_ready got=%b expected=1", READY); end
    if (STATE !== 2'd3) begin errors++; $display("FAIL sw_run_state got=%0d expected=3", STATE); end
    $display("test_sw_req done cyc=%0d", cyc);
  endtask

  task automatic test_loss_sw_coincide();
    int t0;
    do_reset(1'b1);
    RESETN = 1'b1;
    t0 = cyc + 2;
    push_release(t0, 2);
    wait_to(t0 + 9);
    LOCK = 1'b0;
    push_drop(t0 + 14);
    push_loss(t0 + 14);
    wait_to(t0 + 13);
    SW_RST_REQ = 1'b1;
    checks++;
    if (RST_N_OUT !== 4'b0011) begin errors++; $display("FAIL coinc_pre_rst got=%b expected=0011", RST_N_OUT); end
    wait_to(t0 + 14);
    SW_RST_REQ = 1'b0;
    checks += 2;
    if (STATE !== 2'd0) begin errors++; $display("FAIL coinc_state got=%0d expected=0", STATE); end
    if (LOSS_CNT !== 2'(exp_cnt)) begin errors++; $display("FAIL coinc_cnt got=%0d expected=%0d", LOSS_CNT, exp_cnt); end
    wait_to(t0 + 15);
    checks++;
    if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL coinc_pulse_width got=%b expected=0", LOCK_LOST); end
    $display("test_loss_sw_coincide done cyc=%0d", cyc);
  endtask

  task automatic test_cnt_saturate();
    int t0;
    int n;
    do_reset(1'b0);
    RESETN = 1'b1;
    LOCK   = 1'b1;
    t0 = cyc + 2;
    for (int i = 0; i < 5; i++) begin
      push_release(t0, 2);
      wait_to(t0 + 9);
      n = cyc;
      LOCK = 1'b0;
      push_drop(n + 5);
      push_loss(n + 5);
      wait_to(n + 5);
      checks++;
      if (LOSS_CNT !== 2'(exp_cnt)) begin errors++; $display("FAIL sat_cnt iter=%0d got=%0d expected=%0d", i, LOSS_CNT, exp_cnt); end
      LOCK = 1'b1;
      t0 = n + 7;
    end
    push_release(t0, 2);
    wait_to(t0 + 13);
    RESETN = 1'b0;
    push_drop(t0 + 14);
    wait_to(t0 + 14);
    checks += 4;
    if (RST_N_OUT !== 4'b0000) begin errors++; $display("FAIL abort_rst got=%b expected=0000", RST_N_OUT); end
    if (LOSS_CNT !== 2'd0) begin errors++; $display("FAIL abort_cnt got=%0d expected=0", LOSS_CNT); end
    if (READY !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b expected=0", READY); end
    if (STATE !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d expected=0", STATE); end
    exp_cnt = 0;
    $display("test_cnt_saturate done cyc=%0d", cyc);
  endtask

  initial begin
    RESETN     = 1'b0;
    LOCK       = 1'b0;
    SW_RST_REQ = 1'b0;
    test_reset();
    test_release_seq();
    test_stable_glitch();
    test_loss_filter();
    test_sw_req();
    test_loss_sw_coincide();
    test_cnt_saturate();
    repeat (5) @(negedge CLK0);
    checks += 2;
    if (rst_q.size() != 0) begin errors++; $display("FAIL rst_queue_drain got=%0d pending expected=0", rst_q.size()); end
    if (loss_q.size() != 0) begin errors++; $display("FAIL loss_queue_drain got=%0d pending expected=0", loss_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
